// File: rtl/bcd_feeder_pkg.sv
// bcd_feeder_pkg: shared FSM states and constants for the BCD display feeder
package bcd_feeder_pkg;
   typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;
   localparam int unsigned MAX_DEC      = 9999;
   localparam logic [15:0] ERR_CODE_DEF = 16'hEEEE;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: per-nibble add-3-if-at-least-5 correction for double dabble
module bcd_dabble_step (
   input  logic [15:0] acc_i,
   output logic [15:0] acc_o
);
   for (genvar i = 0; i < 4; i++) begin : g_nib
      assign acc_o[4*i +: 4] = (acc_i[4*i +: 4] >= 4'd5) ? acc_i[4*i +: 4] + 4'd3 : acc_i[4*i +: 4];
   end
endmodule

// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder: sequential binary-to-BCD converter, one bit per clock,
// feeding a 4-digit display with a one-cycle load strobe.
module bcd_display_feeder
   import bcd_feeder_pkg::*;
#(
   parameter int          IN_W     = 14,
   parameter logic [15:0] ERR_CODE = ERR_CODE_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IN_W-1:0] bin_value,
   input  logic            load,
   output logic            busy,
   output logic            overflow,
   output logic [15:0]     displayed_number,
   output logic            display_sel
);
   state_t          state_q, state_d;
   logic [IN_W-1:0] opr_q, opr_d;
   logic [15:0]     acc_q, acc_d, adj, shl;
   logic [4:0]      cnt_q, cnt_d;
   logic [15:0]     disp_q, disp_d;
   logic            ovf_q, ovf_d, sel_q, sel_d, busy_q, busy_d;

   bcd_dabble_step u_step (.acc_i(acc_q), .acc_o(adj));

   assign shl = {adj[14:0], opr_q[IN_W-1]};

   always_comb begin
      state_d = state_q;
      opr_d   = opr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      sel_d   = 1'b0;
      case (state_q)
         IDLE: if (load) begin
            opr_d   = bin_value;
            state_d = CHECK;
         end
         CHECK: if (32'(opr_q) > MAX_DEC) begin
            state_d = DONE;
            disp_d  = ERR_CODE;
            ovf_d   = 1'b1;
            sel_d   = 1'b1;
         end else begin
            acc_d   = '0;
            cnt_d   = 5'(IN_W);
            state_d = SHIFT;
         end
         SHIFT: begin
            acc_d = shl;
            opr_d = {opr_q[IN_W-2:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            // outputs are registered, so the result is latched on entry to DONE
            if (cnt_q == 5'd1) begin
               state_d = DONE;
               disp_d  = shl;
               ovf_d   = 1'b0;
               sel_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         opr_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opr_q   <= opr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

   assign busy             = busy_q;
   assign overflow         = ovf_q;
   assign displayed_number = disp_q;
   assign display_sel      = sel_q;
endmodule

// File: tb/tb_bcd_display_feeder.sv
// tb_bcd_display_feeder: table vectors, corner sequences and random values
// checked against a decimal-digit reference model.
module tb_bcd_display_feeder;
   localparam int IN_W = 14;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [IN_W-1:0] bin_value = '0;
   logic            load = 1'b0;
   logic            busy, overflow, display_sel;
   logic [15:0]     displayed_number;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobes[$];

   bcd_display_feeder #(.IN_W(IN_W)) dut (
      .clk(clk), .reset(reset), .bin_value(bin_value), .load(load),
      .busy(busy), .overflow(overflow),
      .displayed_number(displayed_number), .display_sel(display_sel)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (display_sel === 1'b1) strobes.push_back(cyc);

   typedef struct {
      int          val;
      logic [15:0] disp;
      logic        ovf;
      int          lat;
   } vec_t;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_bcd(int v);
      if (v > 9999) return 16'hEEEE;
      return 16'(((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
   endfunction

   // Issues a load in the current cycle and waits for its strobe; optionally
   // pulses a second (to be ignored) load of 1111 ign_at cycles into the run.
   task automatic run_conv(int v, logic [15:0] ed, logic eo, int el, int ign_at, string nm);
      int t0, n0, k;
      bin_value = IN_W'(v);
      load = 1'b1;
      tick();
      load = 1'b0;
      t0 = cyc;
      n0 = strobes.size();
      chk({nm, " busy_start"}, 32'(busy), 32'd1);
      k = 0;
      while (strobes.size() == n0 && k < 40) begin
         if (k == ign_at) begin
            bin_value = IN_W'(1111);
            load = 1'b1;
         end else load = 1'b0;
         tick();
         k++;
      end
      load = 1'b0;
      if (strobes.size() == n0) begin
         chk({nm, " timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({nm, " latency"}, 32'(strobes[n0] - t0), 32'(el));
      chk({nm, " disp"}, 32'(displayed_number), 32'(ed));
      chk({nm, " ovf"}, 32'(overflow), 32'(eo));
      chk({nm, " busy_done"}, 32'(busy), 32'd1);
      tick();
      chk({nm, " sel_after"}, 32'(display_sel), 32'd0);
      chk({nm, " busy_after"}, 32'(busy), 32'd0);
      chk({nm, " disp_held"}, 32'(displayed_number), 32'(ed));
   endtask

   initial begin
      vec_t vecs[7];
      int n0, v;
      vecs[0] = '{1234,  16'h1234, 1'b0, 15};
      vecs[1] = '{0,     16'h0000, 1'b0, 15};
      vecs[2] = '{9999,  16'h9999, 1'b0, 15};
      vecs[3] = '{10000, 16'hEEEE, 1'b1, 1};
      vecs[4] = '{42,    16'h0042, 1'b0, 15};
      vecs[5] = '{16383, 16'hEEEE, 1'b1, 1};
      vecs[6] = '{9,     16'h0009, 1'b0, 15};

      repeat (3) tick();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst ovf", 32'(overflow), 32'd0);
      chk("rst disp", 32'(displayed_number), 32'd0);
      chk("rst sel", 32'(display_sel), 32'd0);
      reset = 1'b1;
      tick();

      foreach (vecs[i])
         run_conv(vecs[i].val, vecs[i].disp, vecs[i].ovf, vecs[i].lat, -1, $sformatf("vec%0d", i));

      run_conv(0, 16'h0000, 1'b0, 15, -1, "b2b_a");
      run_conv(9999, 16'h9999, 1'b0, 15, -1, "b2b_b");
      chk("b2b spacing", 32'(strobes[strobes.size()-1] - strobes[strobes.size()-2]), 32'd17);

      run_conv(5678, 16'h5678, 1'b0, 15, 4, "ignore");
      n0 = strobes.size();
      repeat (20) tick();
      chk("ignore no_extra_strobe", 32'(strobes.size()), 32'(n0));
      chk("ignore idle", 32'(busy), 32'd0);

      run_conv(12000, 16'hEEEE, 1'b1, 1, -1, "pre_rst");
      bin_value = IN_W'(4321);
      load = 1'b1;
      tick();
      load = 1'b0;
      repeat (7) tick();
      reset = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort disp", 32'(displayed_number), 32'd0);
      chk("abort ovf", 32'(overflow), 32'd0);
      chk("abort sel", 32'(display_sel), 32'd0);
      n0 = strobes.size();
      tick();
      tick();
      reset = 1'b1;
      repeat (20) tick();
      chk("abort no_strobe", 32'(strobes.size()), 32'(n0));
      run_conv(7, 16'h0007, 1'b0, 15, -1, "after_rst");

      for (int i = 0; i < 300; i++) begin
         v = (i % 3 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
         run_conv(v, ref_bcd(v), v > 9999, v > 9999 ? 1 : 15, -1, $sformatf("rnd%0d_%0d", i, v));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
